change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//  Output end of the coin interface. The vending FSM counts incoming N/D coin pulses; this block pays coins back out.
//  Vending FSM issues a change request, given in nickel units. Block drives one-cycle nickel/dime eject pulses to the
//  coin motors, waits for each motor acknowledge, then reports done or error. Sits between vending FSM and coin hardware.
// PARAMETERS
//  AMT_W        5   width of amount, in nickel units (1 unit = 5c, dime = 2 units)
//  ACK_TIMEOUT  16  cycles allowed in WAIT_ACK before error; >=2
//  DIME_STOCK   20  dime count loaded at reset (INVENTORY_EN only)
//  NICKEL_STOCK 20  nickel count loaded at reset (INVENTORY_EN only)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  req        in   1      change request strobe; sampled only in IDLE
//  amount     in   AMT_W  change owed in nickel units; sampled with req
//  motor_ack  in   1      coin mechanism has ejected the last commanded coin
//  disp_n     out  1      one-cycle nickel eject pulse
//  disp_d     out  1      one-cycle dime eject pulse
//  busy       out  1      high from the cycle after req is accepted until DONE/ERR exit
//  done       out  1      one-cycle pulse when the full amount has been paid
//  err        out  1      sticky error level; cleared by reset or by the next accepted req
//  dime_empty out  1      dime_cnt==0 (INVENTORY_EN only)
//  nick_empty out  1      nick_cnt==0 (INVENTORY_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, rem=0, timer=0; disp_n, disp_d, busy, done, err all 0. Any in-flight payout is discarded.
//  All outputs are registered/Moore-decoded. No combinational path from an input to an output.
//  States: IDLE, PICK, FIRE, WAIT_ACK, DONE, ERR.
//  IDLE: if req, latch rem<=amount, clear err, go to PICK. req while busy is ignored (no queueing).
//  PICK: if rem>=2, sel=dime; else if rem==1, sel=nickel; if rem==0, go to DONE. Otherwise go to FIRE.
//  FIRE: exactly one cycle. disp_d=sel_dime, disp_n=!sel_dime; timer<=0; go to WAIT_ACK.
//  WAIT_ACK: on motor_ack, rem<=rem-(sel_dime?2:1) and go to PICK. Otherwise timer++.
//    When timer==ACK_TIMEOUT-1 with no ack, go to ERR. If ack and timeout coincide, ack wins.
//  DONE: done=1 for one cycle, then IDLE. ERR: err<=1, then IDLE (err stays high).
//  motor_ack outside WAIT_ACK is ignored. amount==0 gives done 2 cycles after req, with no eject pulse.
//  Latency: req at cycle t -> PICK at t+1 -> first disp_* at t+2. Each coin costs 3 cycles + ack wait.
//  Greedy payout: dimes first, then at most one nickel. rem is never negative (selection guarantees this).
// CONFIGURATION
//  CHANGE_DISP_INVENTORY_EN defined:
//    dime_cnt/nick_cnt registers load DIME_STOCK/NICKEL_STOCK at reset; the acked coin type is decremented on ack.
//    PICK picks a dime only if rem>=2 && dime_cnt>0; else a nickel if nick_cnt>0; else go to ERR (rem not paid).
//    dime_empty/nick_empty ports exist.
//  Not defined: unlimited supply, no counters, no empty ports; selection is pure greedy.
// STRUCTURE
//  Package vend_pkg: state enum (disp_state_t), coin unit constants NICKEL_U=1 and DIME_U=2, AMT_W default.
//    Shared with the vending FSM.
//  Sub-module ack_timer: clear/enable counter with an expired flag at ACK_TIMEOUT-1. Reusable for coin-in debounce.
// TESTING
//  T1 reset mid-payout: req amount=6, assert reset during WAIT_ACK
//    -> all outputs 0 next cycle, no further disp_*.
//  T2 amount=7, ack 2 cycles after each pulse
//    -> disp_d x3 then disp_n x1; done once; busy low after done; err=0.
//  T3 amount=0 -> done at t+2, no disp_*; req held high while busy -> no second payout until IDLE.
//  T4 no motor_ack after the first disp_d -> err=1 after ACK_TIMEOUT cycles (16), done never pulses;
//     next req clears err.
//  T5 ack arrives on the exact timeout cycle -> treated as success, no err; stray ack in IDLE has no effect.
//  T6 (INVENTORY_EN, DIME_STOCK=1) amount=4
//     -> disp_d, disp_n, disp_n; dime_empty=1 after the first ack; NICKEL_STOCK=0 case -> err.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending types: payout FSM states, coin unit values and the default amount width.
// Also used by the vending FSM on the coin-in side.
package vend_pkg;

    localparam int AMT_W_DEF = 5;
    localparam int NICKEL_U  = 1;
    localparam int DIME_U    = 2;
    localparam int INV_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PICK     = 3'd1,
        S_FIRE     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } disp_state_t;

    // Value in nickel units of the coin currently selected
    function automatic logic [1:0] coin_units(input logic sel_dime);
        if (sel_dime) begin
            return 2'(DIME_U);
        end else begin
            return 2'(NICKEL_U);
        end
    endfunction

endpackage

// File: rtl/change_dispenser_ack_timer.sv
// ack_timer: clearable, enabled up-counter that flags expiry at LIMIT-1 and holds there.
// Generic enough to serve as a coin-in debounce timer.
module ack_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT);

    logic [CW-1:0] r_cnt;

    // Count while enabled; saturate at the terminal value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy dime/nickel payout with per-coin motor handshake and ack timeout.
// Optional coin inventory tracking is enabled by defining CHANGE_DISP_INVENTORY_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = AMT_W_DEF,
    parameter int ACK_TIMEOUT = 16
`ifdef CHANGE_DISP_INVENTORY_EN
    ,
    parameter int DIME_STOCK   = 20,
    parameter int NICKEL_STOCK = 20
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             motor_ack,
    output logic             disp_n,
    output logic             disp_d,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef CHANGE_DISP_INVENTORY_EN
    ,
    output logic             dime_empty,
    output logic             nick_empty
`endif
);

    disp_state_t      r_state;
    disp_state_t      w_next;
    logic [AMT_W-1:0] r_rem;
    logic             r_sel_dime;
    logic             w_pick_dime;
    logic             r_err;
    logic             w_expired;
    logic             w_dime_ok;
    logic             w_nick_ok;
    logic             w_rem_zero;
    logic             w_rem_ge2;

    assign w_rem_zero = (r_rem == '0);
    assign w_rem_ge2  = (r_rem >= AMT_W'(DIME_U));

    ack_timer #(
        .LIMIT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (r_state == S_FIRE),
        .en     (r_state == S_WAIT_ACK),
        .expired(w_expired)
    );

`ifdef CHANGE_DISP_INVENTORY_EN
    logic [INV_W-1:0] r_dime_cnt;
    logic [INV_W-1:0] r_nick_cnt;

    // Stock counters: the coin type that was acknowledged leaves the hopper
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dime_cnt <= INV_W'(DIME_STOCK);
            r_nick_cnt <= INV_W'(NICKEL_STOCK);
        end else if (r_state == S_WAIT_ACK && motor_ack) begin
            if (r_sel_dime) begin
                r_dime_cnt <= r_dime_cnt - INV_W'(1);
            end else begin
                r_nick_cnt <= r_nick_cnt - INV_W'(1);
            end
        end
    end

    assign w_dime_ok  = (r_dime_cnt != '0);
    assign w_nick_ok  = (r_nick_cnt != '0);
    assign dime_empty = !w_dime_ok;
    assign nick_empty = !w_nick_ok;
`else
    assign w_dime_ok = 1'b1;
    assign w_nick_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and coin selection; an ack on the expiry cycle still counts as success
    always_comb begin
        w_next      = r_state;
        w_pick_dime = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next = S_PICK;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PICK: begin
                if (w_rem_zero) begin
                    w_next = S_DONE;
                end else if (w_rem_ge2 && w_dime_ok) begin
                    w_pick_dime = 1'b1;
                    w_next      = S_FIRE;
                end else if (w_nick_ok) begin
                    w_next = S_FIRE;
                end else begin
                    w_next = S_ERR;
                end
            end
            S_FIRE:     w_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (motor_ack) begin
                    w_next = S_PICK;
                end else if (w_expired) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_WAIT_ACK;
                end
            end
            S_DONE:     w_next = S_IDLE;
            S_ERR:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Remaining amount, latched coin choice and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem      <= '0;
            r_sel_dime <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_rem <= amount;
                        r_err <= 1'b0;
                    end
                end
                S_PICK:     r_sel_dime <= w_pick_dime;
                S_WAIT_ACK: begin
                    if (motor_ack) begin
                        r_rem <= r_rem - AMT_W'(coin_units(r_sel_dime));
                    end
                end
                S_ERR:      r_err <= 1'b1;
                default:    r_err <= r_err;
            endcase
        end
    end

    assign disp_d = (r_state == S_FIRE) && r_sel_dime;
    assign disp_n = (r_state == S_FIRE) && !r_sel_dime;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign err    = r_err;

endmodule
